uart_tx_sequencer: RTL and testbench
====================================

// Module: uart_tx_sequencer
// PURPOSE
//  Queues transmit bytes from the APB side and sequences the UART transmitter, one frame at a time.
//  For each byte: load tx_data, pulse tx_start, wait tx_done, hold an inter-frame guard gap.
//  Sits between the register interface (TRANSFER_DATA push, status/enable bits) and the UART TX core.
//  Replaces manual CPU polling of tx_done / re-arming of uart_enable.
// PARAMETERS
//  FIFO_DEPTH      8      byte queue depth; power of two, >=2
//  GAP_CYCLES      2      idle PCLK cycles between tx_done and the next LOAD; 0 allowed
//  TIMEOUT_CYCLES  65535  WAIT_DONE watchdog limit (UART_SEQ_TIMEOUT_EN builds only)
// PORTS
//  PCLK         in   1   clock
//  PRESETn      in   1   asynchronous active-low reset
//  push         in   1   enqueue push_data this cycle
//  push_data    in   8   byte to transmit
//  flush        in   1   discard all queued bytes
//  seq_enable   in   1   sequencer run enable (uart_enable bit0)
//  br_cfg_err   in   1   baud config error; blocks new frames
//  tx_done      in   1   UART frame-complete pulse
//  ovf_clr      in   1   clear ovf_flag
//  tx_start     out  1   one-cycle start pulse to UART
//  tx_data      out  8   byte under transmission; stable LOAD..end of WAIT_DONE
//  busy         out  1   FSM not in IDLE
//  level        out  log2(FIFO_DEPTH)+1  queued byte count
//  full/empty   out  1   queue status
//  ovf_flag     out  1   sticky: push dropped while full
//  drain_irq    out  1   one-cycle pulse: frame ended and queue empty
//  to_flag      out  1   sticky watchdog expiry (0 without macro)
// BEHAVIOUR
//  Reset: FSM=IDLE, queue empty, tx_start=0, tx_data=0, busy=0, level=0, full=0, empty=1,
//   ovf_flag=0, drain_irq=0, to_flag=0. Reset mid-frame abandons the frame silently.
//  FSM: IDLE -(!empty & seq_enable & !br_cfg_err)-> LOAD (pop, register tx_data) -> START
//   (tx_start=1) -> WAIT_DONE -(tx_done)-> GAP (GAP_CYCLES counts; skipped if 0) -> IDLE.
//  Latency: push sampled at edge 0 into empty queue, FSM idle -> tx_start high in cycle after edge 2.
//  tx_done outside WAIT_DONE ignored; tx_done in START ignored (UART cannot finish same cycle).
//  seq_enable low or br_cfg_err high: holds IDLE only; an in-flight frame runs to tx_done.
//  Push while full: byte dropped, ovf_flag set. Push+pop same cycle when full: accepted, level unchanged.
//  flush: level->0 next cycle; does not abort current frame; flush+push same cycle: flush wins.
//  ovf_clr and set same cycle: set wins. Pointers wrap modulo FIFO_DEPTH.
//  drain_irq: pulses on exit from WAIT_DONE (GAP_CYCLES=0) or GAP when empty.
// CONFIGURATION
//  UART_SEQ_TIMEOUT_EN defined: counter runs in WAIT_DONE; reaching TIMEOUT_CYCLES without
//   tx_done sets to_flag (cleared only by reset), goes to GAP, byte lost, drain_irq rules apply.
//  Undefined: WAIT_DONE waits indefinitely; to_flag tied 0; no counter logic.
// STRUCTURE
//  Package uart_seq_pkg: state enum (IDLE, LOAD, START, WAIT_DONE, GAP), DATA_W=8, level width func.
//  Sub-module uart_seq_fifo: sync FIFO (push/pop/flush, full/empty/level); FSM and flags in top.
// TESTING
//  Push 0xA5 idle, enable=1 -> tx_start at cycle 3, tx_data=0xA5; tx_done -> GAP 2 cycles, drain_irq once.
//  Push 0x01..0x08 back-to-back -> full=1; 9th push 0xFF -> dropped, ovf_flag=1; ovf_clr -> 0; bytes out in order.
//  br_cfg_err=1 with 3 bytes queued -> no tx_start; deassert -> 3 frames, each separated by GAP_CYCLES.
//  flush during WAIT_DONE with level=4 -> level=0, current frame completes, drain_irq on its exit.
//  Macro on, TIMEOUT_CYCLES=16, no tx_done -> to_flag=1 at cycle 16 of WAIT_DONE, next byte proceeds.
//  PRESETn low in WAIT_DONE with level=3 -> all outputs at reset values, queue empty.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: shared state encoding, data width and level-width helper for the UART TX sequencer.
package uart_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        GAP
    } seq_state_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_seq_fifo.sv
// uart_seq_fifo: synchronous byte queue with push/pop/flush; flush wins over a same-cycle push.
module uart_seq_fifo
    import uart_seq_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = lvl_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [LW-1:0]     level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              drop_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o    = cnt_q == LW'(DEPTH);
    assign empty_o   = cnt_q == '0;
    assign level_o   = cnt_q;
    assign rd_data_o = mem_q[rd_q];

    // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && !do_push;
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        cnt_d   = flush_i ? '0 : cnt_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: drains a byte queue into the UART TX core one frame at a time with a guard gap.
// Define UART_SEQ_TIMEOUT_EN to add the WAIT_DONE watchdog that drives to_flag.
module uart_tx_sequencer
    import uart_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         flush,
    input  logic                         seq_enable,
    input  logic                         br_cfg_err,
    input  logic                         tx_done,
    input  logic                         ovf_clr,
    output logic                         tx_start,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         busy,
    output logic [lvl_w(FIFO_DEPTH)-1:0] level,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_flag,
    output logic                         drain_irq,
    output logic                         to_flag
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, rd_data;
    logic [GW-1:0]     gap_q, gap_d;
    logic              ovf_q, drain_q, pop, drop, frame_end, timeout;

    uart_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .push_i   (push),
        .data_i   (push_data),
        .pop_i    (pop),
        .flush_i  (flush),
        .rd_data_o(rd_data),
        .level_o  (level),
        .full_o   (full),
        .empty_o  (empty),
        .drop_o   (drop)
    );

    assign tx_start  = state_q == START;
    assign busy      = state_q != IDLE;
    assign tx_data   = tx_data_q;
    assign ovf_flag  = ovf_q;
    assign drain_irq = drain_q;

    // Enable/config gating only blocks leaving IDLE; a frame already launched always runs out.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: if (!empty && seq_enable && !br_cfg_err) begin
                state_d   = LOAD;
                pop       = 1'b1;
                tx_data_d = rd_data;
            end
            LOAD:  state_d = START;
            START: state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done || timeout) begin
                state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                frame_end = GAP_CYCLES == 0;
                gap_d     = '0;
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            gap_q     <= gap_d;
            ovf_q     <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
            drain_q   <= frame_end && empty;
        end
    end

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;
    logic          to_q;
    assign timeout = state_q == WAIT_DONE && !tx_done && to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign to_flag = to_q;
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == WAIT_DONE) ? to_cnt_q + TW'(1) : '0;
            to_q     <= to_q || timeout;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed self-checking bench for the default build (FIFO_DEPTH=8, GAP_CYCLES=2).
module tb_uart_tx_sequencer;

    logic       PCLK = 1'b0, PRESETn = 1'b0;
    logic       push = 1'b0, flush = 1'b0, seq_enable = 1'b0, br_cfg_err = 1'b0;
    logic       tx_done = 1'b0, ovf_clr = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       tx_start, busy, full, empty, ovf_flag, drain_irq, to_flag;
    logic [7:0] tx_data;
    logic [3:0] level;
    int         vectors = 0, errors = 0;
    int         n;

    always #5 PCLK = ~PCLK;

    uart_tx_sequencer dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .push      (push),
        .push_data (push_data),
        .flush     (flush),
        .seq_enable(seq_enable),
        .br_cfg_err(br_cfg_err),
        .tx_done   (tx_done),
        .ovf_clr   (ovf_clr),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .ovf_flag  (ovf_flag),
        .drain_irq (drain_irq),
        .to_flag   (to_flag)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(posedge PCLK);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1;
        push_data = b;
        tick();
        push = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (tx_start) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("start_timeout", 0, 1);
    endtask

    task automatic finish_frame();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_txdata", tx_data, 0);
        check("rst_flags", {tx_start, full, ovf_flag, drain_irq, to_flag}, 0);
        PRESETn = 1'b1;
        tick();

        // single byte latency, guard gap and drain pulse
        seq_enable = 1'b1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("done_idle_ignored", busy, 0);
        push_byte(8'hA5);
        wait_start(n);
        check("latency", n, 2);
        check("tx_data_a5", tx_data, 8'hA5);
        finish_frame();
        tick();
        check("gap1_busy", busy, 1);
        check("gap1_drain", drain_irq, 0);
        tick();
        check("gap_exit_busy", busy, 0);
        check("drain_pulse", drain_irq, 1);
        tick();
        check("drain_clear", drain_irq, 0);

        // fill, overflow, ovf priority, push+pop while full, in-order drain
        seq_enable = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        check("full_level", level, 8);
        check("full", full, 1);
        push_byte(8'hFF);
        check("ovf_set", ovf_flag, 1);
        check("ovf_level", level, 8);
        ovf_clr = 1'b1;
        push_byte(8'hEE);
        check("ovf_set_wins", ovf_flag, 1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_flag, 0);
        seq_enable = 1'b1;
        push_byte(8'h09);
        check("pushpop_full_level", level, 8);
        check("pushpop_no_ovf", ovf_flag, 0);
        for (int i = 1; i <= 9; i++) begin
            wait_start(n);
            check($sformatf("order_%0d", i), tx_data, i);
            if (i > 1) check($sformatf("gap_%0d", i), n, 4);
            finish_frame();
        end
        tick(2);
        check("drain_after_9", drain_irq, 1);
        check("empty_after_9", empty, 1);

        // baud config error holds idle; tx_done during START is ignored
        br_cfg_err = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start || busy) n++;
        end
        check("cfg_err_hold", n, 0);
        check("cfg_err_level", level, 3);
        br_cfg_err = 1'b0;
        wait_start(n);
        check("cfg_byte1", tx_data, 8'h11);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick(3);
        check("done_in_start_ignored", busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            wait_start(n);
            check($sformatf("cfg_gap_%0d", i), n, 4);
            check($sformatf("cfg_byte%0d", i), tx_data, 8'h11 * i);
            finish_frame();
        end
        tick(2);
        check("cfg_drain", drain_irq, 1);

        // flush in WAIT_DONE keeps current frame
        seq_enable = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        seq_enable = 1'b1;
        wait_start(n);
        tick();
        check("pre_flush_level", level, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_busy", busy, 1);
        check("flush_txdata", tx_data, 8'hA0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("flush_drain_early", drain_irq, 0);
        tick();
        check("flush_drain", drain_irq, 1);
        seq_enable = 1'b0;
        flush = 1'b1;
        push_byte(8'h5A);
        flush = 1'b0;
        check("flush_wins", level, 0);

        // reset mid-frame
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        seq_enable = 1'b1;
        wait_start(n);
        tick();
        check("pre_rst_level", level, 3);
        PRESETn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_txdata", tx_data, 0);
        check("arst_flags", {tx_start, full, ovf_flag, drain_irq, to_flag}, 0);
        #2;
        PRESETn = 1'b1;
        tick(3);
        check("post_rst_idle", {busy, tx_start}, 0);
        check("post_rst_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
